// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the PC, issues in-order IMEM requests under a
// credit limit, buffers responses with their PCs, and squashes wrong-path fetches on redirect.
module fetch_queue #(
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [INSTRUCTION_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_en,
  input  logic [INSTRUCTION_WIDTH-1:0]  redirect_target,
  output logic                          imem_req,
  output logic [INSTRUCTION_WIDTH-1:0]  imem_addr,
  input  logic                          imem_gnt,
  input  logic                          imem_rvalid,
  input  logic [INSTRUCTION_WIDTH-1:0]  imem_rdata,
  output logic                          inst_valid,
  output logic [INSTRUCTION_WIDTH-1:0]  inst_out,
  output logic [INSTRUCTION_WIDTH-1:0]  inst_pc,
  input  logic                          inst_ready,
  output logic [$clog2(DEPTH):0]        outstanding
);

  localparam int unsigned IW = INSTRUCTION_WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic [IW-1:0] pc;
  logic [CW-1:0] count;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] out_next;
  logic [SW-1:0] credit_sum;

  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;
  logic [AW-1:0] fifo_wr;
  logic [AW-1:0] fifo_rd;

  logic [IW-1:0] tag_mem  [DEPTH];
  logic [IW-1:0] data_mem [DEPTH];
  logic [IW-1:0] pc_mem   [DEPTH];

  logic grant;
  logic resp;
  logic resp_drop;
  logic push;
  logic pop;

  // Handshake decode; FIFO occupancy plus in-flight requests never exceeds DEPTH.
  always_comb begin
    credit_sum = SW'(count) + SW'(outstanding);
    imem_req   = !rst && (credit_sum < SW'(DEPTH));
    grant      = imem_req && imem_gnt;
    resp       = imem_rvalid && (outstanding != '0);
    resp_drop  = resp && (drop_cnt != '0);
    push       = resp && !resp_drop && !redirect_en;
    pop        = inst_valid && inst_ready && !redirect_en;
    out_next   = outstanding + CW'(grant) - CW'(resp);
  end

  assign imem_addr  = pc;
  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? data_mem[fifo_rd] : '0;
  assign inst_pc    = inst_valid ? pc_mem[fifo_rd]   : '0;

  // Control state; a redirect wins over normal PC/FIFO updates and arms the drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
    end else begin
      outstanding <= out_next;
      if (grant) tag_wr <= tag_wr + AW'(1);
      if (resp)  tag_rd <= tag_rd + AW'(1);
      if (redirect_en) begin
        pc       <= redirect_target;
        count    <= '0;
        fifo_wr  <= '0;
        fifo_rd  <= '0;
        drop_cnt <= out_next;
      end else begin
        if (grant)     pc       <= pc + IW'(4);
        if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (push)      fifo_wr  <= fifo_wr + AW'(1);
        if (pop)       fifo_rd  <= fifo_rd + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wr] <= pc;
    if (push) begin
      data_mem[fifo_wr] <= imem_rdata;
      pc_mem[fifo_wr]   <= tag_mem[tag_rd];
    end
  end

  rvalid_has_request: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outstanding == '0)))
    else $error("fetch_queue: imem_rvalid with no outstanding request");

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front-end that sits directly upstream of the IF/ID register of the 3-stage pipeline, replacing the bare program counter.
- Owns the PC and issues in-order requests to IMEM over a request/grant plus response-valid handshake.
- Buffers returned instructions in a small FIFO and presents them to IF/ID with valid/ready.
- On a branch redirect, flushes the FIFO and discards responses still in flight, so the pipeline never sees wrong-path instructions.

Parameters:
- INSTRUCTION_WIDTH, 32, width of the instruction word and of every address.
- DEPTH, 4, FIFO entries; also the cap on (FIFO occupancy + in-flight requests). Must be a power of 2, ≥2.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect_en  input  1  taken branch from the branch unit; one-cycle pulse.
- redirect_target  input  INSTRUCTION_WIDTH  new fetch address, sampled when redirect_en=1.
- imem_req  output  1  fetch request valid.
- imem_addr  output  INSTRUCTION_WIDTH  fetch address; equals the PC register.
- imem_gnt  input  1  IMEM accepts the request this cycle when imem_req=1.
- imem_rvalid  input  1  response valid; responses return in order, latency ≥1 cycle after grant.
- imem_rdata  input  INSTRUCTION_WIDTH  response instruction.
- inst_valid  output  1  FIFO head is valid.
- inst_out  output  INSTRUCTION_WIDTH  head instruction; 0 (NOP) when inst_valid=0.
- inst_pc  output  INSTRUCTION_WIDTH  address of the head instruction; 0 when inst_valid=0.
- inst_ready  input  1  downstream consumes the head when inst_valid=1.
- outstanding  output  clog2(DEPTH)+1  in-flight request count (debug/verification).

Behaviour:
- Reset (rst=1 at the clock edge):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - Outputs during and after reset until the first fill: imem_req=0, inst_valid=0, inst_out=0, inst_pc=0.
  - Reset has priority over every other input and aborts any in-flight bookkeeping. Responses arriving after reset for pre-reset requests are the bench's responsibility to suppress.
- Issue:
  - imem_req = !rst && (count + outstanding < DEPTH).
  - A grant (imem_req & imem_gnt) sets pc+=4 and outstanding+=1, and pushes the address into an in-order pc tag queue of depth DEPTH.
- Response (imem_rvalid=1):
  - outstanding-=1 and the pc tag is popped.
  - If drop_cnt>0: drop_cnt-=1 and the data is discarded.
  - Otherwise {imem_rdata, tag} is pushed into the FIFO. The credit rule guarantees the FIFO cannot overflow.
  - imem_rvalid with outstanding=0 is a protocol error: ignore it; an assertion fires in simulation.
- Dequeue: inst_valid & inst_ready pops the head. Head outputs are driven from registered storage, with no combinational path from the imem inputs.
- Same-cycle push and pop: both happen and count is unchanged. Pop of the last entry plus push of a new one gives inst_valid=1 next cycle.
- Redirect (redirect_en=1, not in reset):
  - Next cycle: pc=redirect_target; FIFO emptied (count=0); any dequeue in the redirect cycle is ignored.
  - drop_cnt = outstanding after this cycle's grant/response updates. A request granted in the redirect cycle is wrong-path and is counted.
  - A response arriving in the redirect cycle is consumed by the old bookkeeping (it is either dropped or flushed) and never reaches the FIFO.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Wrap: pc+4 wraps modulo 2^INSTRUCTION_WIDTH. FIFO read/write pointers wrap modulo DEPTH, with an explicit count register for full/empty.
- Latency: first imem_req in the cycle after reset deasserts. With 1-cycle IMEM latency, inst_valid rises 2 cycles after the first grant.

Test Plan:
- Reset release, IMEM grants always, 1-cycle latency, rdata=addr|0xA000_0000, inst_ready=1 -> inst_pc sequence 0,4,8,12…; inst_out=0xA000_0000,0xA000_0004…; one instruction per cycle after a 2-cycle fill.
- inst_ready=0 for 10 cycles, gnt=1 -> exactly DEPTH=4 grants, then imem_req=0; count=4; head stays pc=0; releasing ready drains 0,4,8,12 in order with no loss.
- IMEM latency 3, redirect_en with target 0x100 while outstanding=2 -> next two rvalid beats discarded; next inst_pc=0x100, then 0x104.
- Redirect in the same cycle as a grant to pc=0x20 and an rvalid -> the 0x20 response is dropped; the FIFO shows only 0x200… for target 0x200.
- Redirect to 0xFFFF_FFFC -> inst_pc=0xFFFF_FFFC, then 0x0000_0000 (wrap).
- rst asserted mid-stream with count=3 and outstanding=1 -> next cycle inst_valid=0, inst_out=0, outstanding=0, imem_addr=RESET_PC.
